matrix_row_scanner: RTL and testbench

MATRIX_ROW_SCANNER -- requirements
Module: matrix_row_scanner

---
 rtl/matrix_row_scanner_pkg.sv | 28 ++
 rtl/matrix_scan_timer.sv | 74 +++++++
 rtl/matrix_row_scanner.sv | 73 +++++++
 tb/tb_matrix_row_scanner.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/matrix_row_scanner_pkg.sv
// Shared display package for the LED matrix modules.
// Holds the matrix geometry, the scan FSM state encoding and a small
// row-decode helper used by the scanner top.
package matrix_row_scanner_pkg;

    localparam int ROWS    = 7;
    localparam int COLS    = 5;
    localparam int FRAME_W = ROWS * COLS;
    localparam int ROW_W   = 3;
    localparam int CNT_W   = 16;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic {
        ST_BLANK  = 1'b0,
        ST_ACTIVE = 1'b1
    } scan_state_t;

    function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] r);
        logic [ROWS-1:0] oh;
        oh = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (r == ROW_W'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// Row scan timer: two-state ACTIVE/BLANK FSM sharing one cycle counter.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   en         - advance enable; when low, state/counter/row are frozen
//   row        - current row index 0..ROWS-1
//   active     - high while in ACTIVE
//   row_start  - counter is at zero (first cycle of the current state)
//   wrap       - this enabled cycle ends ACTIVE of the last row (row wraps to 0)
module matrix_scan_timer
    import matrix_row_scanner_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [ROW_W-1:0] row,
    output logic             active,
    output logic             row_start,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYC - 1);

    scan_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ROW_W-1:0] row_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BLANK;
            cnt   <= '0;
            row   <= '0;
        end else if (en) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            row   <= row_nxt;
        end
    end

    // Counter clears on every state change; row advances leaving ACTIVE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        row_nxt   = row;
        wrap      = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (cnt == ACT_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    if (row == ROW_LAST) begin
                        row_nxt = '0;
                        wrap    = en;
                    end else begin
                        row_nxt = row + 1'b1;
                    end
                end
            end
            default: begin
                if (cnt == BLK_LAST) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    assign active    = (state == ST_ACTIVE);
    assign row_start = (cnt == '0);

endmodule

// File: rtl/matrix_row_scanner.sv
// 7x5 LED matrix row scanner with double-buffered frame.
// A loaded frame goes into a shadow register and is only adopted into the
// displayed map at the row 6->0 wrap, so a frame never tears mid-scan.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   en          - scan enable (l forced low and scan frozen when low)
//   frame_in    - new frame, bit row*5+col
//   frame_load  - one-cycle strobe capturing frame_in into the shadow
//   map         - displayed frame
//   l           - one-hot row enables
//   frame_start - pulse on the first lit cycle of row 0
//   load_ack    - pulse the cycle after a pending frame is adopted
module matrix_row_scanner
    import matrix_row_scanner_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_load,
    output logic [FRAME_W-1:0] map,
    output logic [ROWS-1:0]    l,
    output logic               frame_start,
    output logic               load_ack
);

    logic [ROW_W-1:0]   row;
    logic               active;
    logic               row_start;
    logic               wrap;
    logic [FRAME_W-1:0] shadow;
    logic               pending;

    matrix_scan_timer #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .row       (row),
        .active    (active),
        .row_start (row_start),
        .wrap      (wrap)
    );

    // A load on the wrap cycle still adopts the old shadow (read before
    // overwrite) and leaves pending set for the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            pending  <= 1'b0;
            map      <= '0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= wrap && pending;
            if (wrap && pending) map <= shadow;
            if (frame_load) begin
                shadow  <= frame_in;
                pending <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    assign l           = (!rst && en && active) ? row_onehot(row) : '0;
    assign frame_start = !rst && en && active && row_start && (row == '0);

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Randomized self-checking bench for matrix_row_scanner (DIV=4, BLANK_CYC=2).
// The reference tracks scan position as a count of enabled cycles since reset
// and derives row/blank from it arithmetically.
module tb_matrix_row_scanner;

    localparam int D   = 4;
    localparam int B   = 2;
    localparam int SEG = D + B;
    localparam int P   = 7 * SEG;

    logic        clk = 1'b0;
    logic        rst, en, frame_load;
    logic [34:0] frame_in, map;
    logic [6:0]  l;
    logic        frame_start, load_ack;

    always #5 clk = ~clk;

    matrix_row_scanner #(.DIV(D), .BLANK_CYC(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .frame_in    (frame_in),
        .frame_load  (frame_load),
        .map         (map),
        .l           (l),
        .frame_start (frame_start),
        .load_ack    (load_ack)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          p;
    logic [34:0] m_shadow, m_map;
    logic        m_pend, m_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int seg_of();
        return (p % P) / SEG;
    endfunction

    function automatic int off_of();
        return (p % P) % SEG;
    endfunction

    function automatic logic [6:0] exp_l(input logic r, input logic e);
        logic [6:0] one;
        one = 7'd1;
        if (r || !e || off_of() < B) return 7'd0;
        return one << seg_of();
    endfunction

    task automatic model_reset();
        p = 0; m_shadow = '0; m_map = '0; m_pend = 1'b0; m_ack = 1'b0;
    endtask

    task automatic step(input logic r, input logic e, input logic fl, input logic [34:0] fi);
        logic w;
        rst = r; en = e; frame_load = fl; frame_in = fi;
        @(negedge clk);
        chk("l", 64'(l), 64'(exp_l(r, e)));
        chk("frame_start", 64'(frame_start), 64'(!r && e && seg_of() == 0 && off_of() == B));
        chk("map", 64'(map), 64'(m_map));
        chk("load_ack", 64'(load_ack), 64'(m_ack));
        chk("onehot", 64'($countones(l) <= 1), 64'd1);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            w     = e && seg_of() == 6 && off_of() == SEG - 1;
            m_ack = w && m_pend;
            if (w && m_pend) m_map = m_shadow;
            if (fl) begin
                m_shadow = fi;
                m_pend   = 1'b1;
            end else if (w) begin
                m_pend = 1'b0;
            end
            if (e) p = (p + 1) % P;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic run_to(input int s, input int o);
        for (int i = 0; i < 2 * P; i++) begin
            if (seg_of() == s && off_of() == o) break;
            step(1'b0, 1'b1, 1'b0, '0);
        end
    endtask

    initial begin
        logic [63:0] rnd;
        rst = 1'b1; en = 1'b1; frame_load = 1'b0; frame_in = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset release and two full frames
        repeat (3) step(1'b1, 1'b1, 1'b0, '0);
        idle(90);

        // adoption of a load made mid-row-2
        run_to(2, B + 1);
        step(1'b0, 1'b1, 1'b1, 35'h7_0000_0001);
        idle(50);

        // double load in one frame, then a load on the exact wrap cycle
        run_to(1, B);
        step(1'b0, 1'b1, 1'b1, 35'h1_2345_6789);
        run_to(3, B);
        step(1'b0, 1'b1, 1'b1, 35'h5_5555_5555);
        run_to(0, B);
        step(1'b0, 1'b1, 1'b1, 35'h2_AAAA_0F0F);
        run_to(6, SEG - 1);
        step(1'b0, 1'b1, 1'b1, 35'h6_0000_FFFF);
        idle(90);

        // enable hold mid-row-3
        run_to(3, B + 1);
        repeat (10) step(1'b0, 1'b0, 1'b0, '0);
        idle(50);

        // reset during row 5 with a load pending
        run_to(1, B);
        step(1'b0, 1'b1, 1'b1, 35'h3_1111_2222);
        run_to(5, B + 1);
        repeat (3) step(1'b1, 1'b1, 1'b0, '0);
        idle(60);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            rnd = {$urandom, $urandom};
            step($urandom_range(199) == 0, $urandom_range(7) != 0,
                 $urandom_range(11) == 0, rnd[34:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
